// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter: a word pushed into an empty, idle block starts its start bit one cycle after empty drops.
// Backpressure is only the full flag; a push while full is dropped and latches overflow until reset.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 1250,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_W:0]      level,
    output logic                 overflow,
    output logic                 busy,
    output logic                 tx
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0]     T_LAST   = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0]     T_ONE    = TW'(1);
    localparam logic [BW-1:0]     B_LAST   = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]     B_ONE    = BW'(1);
    localparam logic              S_LAST   = (STOP_BITS == 2);
    localparam logic              HAS_PAR  = (PARITY != 0);
    localparam logic              PAR_ODD  = (PARITY == 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W:0]      level_nxt;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    logic [2:0]           state;
    logic [TW-1:0]        timer;
    logic                 timer_end;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;

    // Pop happens either from IDLE or on the very last stop cycle, which is
    // what lets frames run back-to-back without an idle bit in between.
    always_comb begin
        push      = wr_en && !full;
        timer_end = (timer == T_LAST);
        pop       = !empty && ((state == S_IDLE) ||
                    ((state == S_STOP) && timer_end && (stop_idx == S_LAST)));
        head      = mem[rd_ptr];
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LVL_ONE;
        end else if (!push && pop) begin
            level_nxt = level - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level    <= level_nxt;
            full     <= (level_nxt == LVL_FULL);
            empty    <= (level_nxt == '0);
            overflow <= overflow | (wr_en & full);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            timer    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
        end else begin
            if (state != S_IDLE) begin
                timer <= timer_end ? '0 : timer + T_ONE;
            end
            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        shift   <= head;
                        par_bit <= (^head) ^ PAR_ODD;
                        timer   <= '0;
                        state   <= S_START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (timer_end) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                S_DATA: begin
                    if (timer_end) begin
                        if (bit_idx == B_LAST) begin
                            if (HAS_PAR) begin
                                state <= S_PAR;
                                tx    <= par_bit;
                            end else begin
                                state    <= S_STOP;
                                stop_idx <= 1'b0;
                                tx       <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + B_ONE;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end
                end
                S_PAR: begin
                    if (timer_end) begin
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        tx       <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (timer_end) begin
                        if (stop_idx == S_LAST) begin
                            if (pop) begin
                                shift   <= head;
                                par_bit <= (^head) ^ PAR_ODD;
                                state   <= S_START;
                                tx      <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                tx    <= 1'b1;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: five differently-configured instances, each scenario checked cycle by cycle against hand-written frames.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] wr_en;
    logic [4:0] full;
    logic [4:0] empty;
    logic [4:0] overflow;
    logic [4:0] busy;
    logic [4:0] tx;
    logic [7:0] wr_data [4];
    logic [6:0] wr_data7;
    logic [2:0] level0;
    logic [4:0] level1;
    logic [4:0] level2;
    logic [4:0] level3;
    logic [4:0] level4;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .full(full[0]), .empty(empty[0]),
        .level(level0), .overflow(overflow[0]), .busy(busy[0]), .tx(tx[0]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .full(full[1]), .empty(empty[1]),
        .level(level1), .overflow(overflow[1]), .busy(busy[1]), .tx(tx[1]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .full(full[2]), .empty(empty[2]),
        .level(level2), .overflow(overflow[2]), .busy(busy[2]), .tx(tx[2]));
    uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_stop2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[3]), .wr_data(wr_data[3]), .full(full[3]), .empty(empty[3]),
        .level(level3), .overflow(overflow[3]), .busy(busy[3]), .tx(tx[3]));
    uart_tx_fifo #(.CLK_DIV(2), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_7bit (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[4]), .wr_data(wr_data7), .full(full[4]), .empty(empty[4]),
        .level(level4), .overflow(overflow[4]), .busy(busy[4]), .tx(tx[4]));

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = '0;
        for (int i = 0; i < 4; i++) wr_data[i] = 8'h00;
        wr_data7 = 7'h00;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 5'b11111) begin $display("FAIL reset_tx got %b want 11111", tx); n_bad++; end
        n_cmp++; if (busy !== 5'b00000) begin $display("FAIL reset_busy got %b want 00000", busy); n_bad++; end
        n_cmp++; if (empty !== 5'b11111) begin $display("FAIL reset_empty got %b want 11111", empty); n_bad++; end
        n_cmp++; if (full !== 5'b00000) begin $display("FAIL reset_full got %b want 00000", full); n_bad++; end
        n_cmp++; if (overflow !== 5'b00000) begin $display("FAIL reset_overflow got %b want 00000", overflow); n_bad++; end
        n_cmp++; if (level0 !== 3'd0) begin $display("FAIL reset_level got %0d want 0", level0); n_bad++; end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        logic [9:0] exp;
        exp = 10'b1_0100_0001_0;
        @(negedge clk);
        wr_data[0] = 8'h41;
        wr_en[0]   = 1'b1;
        @(negedge clk);
        wr_en[0]   = 1'b0;
        wr_data[0] = 8'hFF;
        n_cmp++; if ({empty[0], busy[0], tx[0]} !== 3'b001) begin
            $display("FAIL 8n1_after_push got empty/busy/tx=%b%b%b want 001", empty[0], busy[0], tx[0]); n_bad++; end
        n_cmp++; if (level0 !== 3'd1) begin $display("FAIL 8n1_level got %0d want 1", level0); n_bad++; end
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            n_cmp++;
            if ({busy[0], tx[0]} !== {1'b1, exp[c/4]}) begin
                $display("FAIL 8n1_cycle%0d got busy/tx=%b%b want 1%b", c, busy[0], tx[0], exp[c/4]); n_bad++;
            end
            @(negedge clk);
        end
        n_cmp++; if ({busy[0], tx[0], empty[0]} !== 3'b011) begin
            $display("FAIL 8n1_end got busy/tx/empty=%b%b%b want 011", busy[0], tx[0], empty[0]); n_bad++; end
    endtask

    task automatic test_parity();
        logic [10:0] exp_e;
        logic [10:0] exp_o;
        exp_e = 11'b1_0_0100_0001_0;
        exp_o = 11'b1_1_0100_0001_0;
        @(negedge clk);
        wr_data[1] = 8'h41;
        wr_data[2] = 8'h41;
        wr_en[2:1] = 2'b11;
        @(negedge clk);
        wr_en[2:1] = 2'b00;
        @(negedge clk);
        for (int c = 0; c < 44; c++) begin
            n_cmp++;
            if ({busy[1], tx[1]} !== {1'b1, exp_e[c/4]}) begin
                $display("FAIL even_cycle%0d got busy/tx=%b%b want 1%b", c, busy[1], tx[1], exp_e[c/4]); n_bad++;
            end
            n_cmp++;
            if ({busy[2], tx[2]} !== {1'b1, exp_o[c/4]}) begin
                $display("FAIL odd_cycle%0d got busy/tx=%b%b want 1%b", c, busy[2], tx[2], exp_o[c/4]); n_bad++;
            end
            @(negedge clk);
        end
        n_cmp++; if (busy[2:1] !== 2'b00) begin $display("FAIL parity_end_busy got %b want 00", busy[2:1]); n_bad++; end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp1;
        logic [10:0] exp2;
        logic        e;
        exp1 = 11'b11_0101_0101_0;
        exp2 = 11'b11_1010_1010_0;
        @(negedge clk);
        wr_data[3] = 8'h55;
        wr_en[3]   = 1'b1;
        @(negedge clk);
        wr_data[3] = 8'hAA;
        @(negedge clk);
        wr_en[3] = 1'b0;
        for (int c = 0; c < 88; c++) begin
            e = (c < 44) ? exp1[c/4] : exp2[(c-44)/4];
            n_cmp++;
            if ({busy[3], tx[3]} !== {1'b1, e}) begin
                $display("FAIL stop2_cycle%0d got busy/tx=%b%b want 1%b", c, busy[3], tx[3], e); n_bad++;
            end
            @(negedge clk);
        end
        n_cmp++; if ({busy[3], tx[3]} !== 2'b01) begin
            $display("FAIL stop2_end got busy/tx=%b%b want 01", busy[3], tx[3]); n_bad++; end
    endtask

    task automatic test_7bit();
        logic [8:0] exp;
        exp = 9'b1_1111111_0;
        @(negedge clk);
        wr_data7 = 7'h7F;
        wr_en[4] = 1'b1;
        @(negedge clk);
        wr_en[4] = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 18; c++) begin
            n_cmp++;
            if ({busy[4], tx[4]} !== {1'b1, exp[c/2]}) begin
                $display("FAIL 7bit_cycle%0d got busy/tx=%b%b want 1%b", c, busy[4], tx[4], exp[c/2]); n_bad++;
            end
            @(negedge clk);
        end
        n_cmp++; if (busy[4] !== 1'b0) begin $display("FAIL 7bit_end_busy got %b want 0", busy[4]); n_bad++; end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        fork
            begin : pusher
                wr_data[0] = 8'h10; wr_en[0] = 1'b1;
                @(negedge clk); wr_data[0] = 8'h21;
                n_cmp++; if (level0 !== 3'd1) begin $display("FAIL ovf_lvl_n1 got %0d want 1", level0); n_bad++; end
                @(negedge clk); wr_data[0] = 8'h22;
                n_cmp++; if ({level0, busy[0]} !== {3'd1, 1'b1}) begin
                    $display("FAIL ovf_pushpop got level=%0d busy=%b want level=1 busy=1", level0, busy[0]); n_bad++; end
                @(negedge clk); wr_data[0] = 8'h23;
                n_cmp++; if (level0 !== 3'd2) begin $display("FAIL ovf_lvl_n3 got %0d want 2", level0); n_bad++; end
                @(negedge clk); wr_data[0] = 8'h24;
                n_cmp++; if (level0 !== 3'd3) begin $display("FAIL ovf_lvl_n4 got %0d want 3", level0); n_bad++; end
                @(negedge clk); wr_data[0] = 8'h25;
                n_cmp++; if ({level0, full[0], overflow[0]} !== {3'd4, 1'b1, 1'b0}) begin
                    $display("FAIL ovf_full got level=%0d full=%b ovf=%b want 4 1 0", level0, full[0], overflow[0]); n_bad++; end
                @(negedge clk); wr_data[0] = 8'h26;
                n_cmp++; if ({level0, overflow[0]} !== {3'd4, 1'b1}) begin
                    $display("FAIL ovf_set got level=%0d ovf=%b want 4 1", level0, overflow[0]); n_bad++; end
                @(negedge clk); wr_en[0] = 1'b0;
                n_cmp++; if ({level0, full[0], overflow[0]} !== {3'd4, 1'b1, 1'b1}) begin
                    $display("FAIL ovf_hold got level=%0d full=%b ovf=%b want 4 1 1", level0, full[0], overflow[0]); n_bad++; end
                repeat (34) @(negedge clk);
                wr_data[0] = 8'h77; wr_en[0] = 1'b1;
                @(negedge clk); wr_en[0] = 1'b0;
                n_cmp++; if ({level0, full[0]} !== {3'd3, 1'b0}) begin
                    $display("FAIL ovf_full_pushpop got level=%0d full=%b want 3 0", level0, full[0]); n_bad++; end
            end
            begin : decoder
                logic [7:0] words [5];
                logic [7:0] got;
                int         t;
                int         lows;
                logic       timed_out;
                words = '{8'h10, 8'h21, 8'h22, 8'h23, 8'h24};
                timed_out = 1'b0;
                for (int w = 0; w < 5 && !timed_out; w++) begin
                    t = 0;
                    while (tx[0] !== 1'b0 && t < 400) begin @(negedge clk); t++; end
                    if (t >= 400) begin
                        n_cmp++; n_bad++; timed_out = 1'b1;
                        $display("FAIL ovf_start_timeout word%0d got no start bit want one within 400 cycles", w);
                    end else begin
                        repeat (2) @(negedge clk);
                        for (int b = 0; b < 8; b++) begin
                            repeat (4) @(negedge clk);
                            got[b] = tx[0];
                        end
                        n_cmp++; if (got !== words[w]) begin
                            $display("FAIL ovf_word%0d got %h want %h", w, got, words[w]); n_bad++; end
                        repeat (4) @(negedge clk);
                        n_cmp++; if (tx[0] !== 1'b1) begin $display("FAIL ovf_stop%0d got %b want 1", w, tx[0]); n_bad++; end
                    end
                end
                lows = 0;
                repeat (60) begin @(negedge clk); if (tx[0] !== 1'b1) lows++; end
                n_cmp++; if (lows !== 0) begin $display("FAIL ovf_extra_frame got %0d low cycles want 0", lows); n_bad++; end
                n_cmp++; if ({busy[0], empty[0], level0, overflow[0]} !== {1'b0, 1'b1, 3'd0, 1'b1}) begin
                    $display("FAIL ovf_drained got busy=%b empty=%b level=%0d ovf=%b want 0 1 0 1",
                             busy[0], empty[0], level0, overflow[0]); n_bad++; end
            end
        join
    endtask

    task automatic test_reset_mid_frame();
        int active;
        @(negedge clk);
        wr_en[0] = 1'b1; wr_data[0] = 8'h31;
        @(negedge clk); wr_data[0] = 8'h32;
        @(negedge clk); wr_data[0] = 8'h33;
        @(negedge clk); wr_data[0] = 8'h34;
        @(negedge clk); wr_en[0] = 1'b0;
        n_cmp++; if (level0 !== 3'd3) begin $display("FAIL mid_queued got %0d want 3", level0); n_bad++; end
        repeat (8) @(negedge clk);
        n_cmp++; if (busy[0] !== 1'b1) begin $display("FAIL mid_busy_before got %b want 1", busy[0]); n_bad++; end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({tx[0], busy[0], empty[0], full[0], overflow[0], level0} !== {5'b10100, 3'd0}) begin
            $display("FAIL mid_reset got tx=%b busy=%b empty=%b full=%b ovf=%b level=%0d want 1 0 1 0 0 0",
                     tx[0], busy[0], empty[0], full[0], overflow[0], level0); n_bad++; end
        rst_n = 1'b1;
        active = 0;
        repeat (100) begin @(negedge clk); if (tx[0] !== 1'b1 || busy[0] !== 1'b0) active++; end
        n_cmp++; if (active !== 0) begin $display("FAIL mid_after_release got %0d active cycles want 0", active); n_bad++; end
        n_cmp++; if (empty[0] !== 1'b1) begin $display("FAIL mid_empty_after got %b want 1", empty[0]); n_bad++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_7bit();
        test_overflow();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, self-contained UART transmitter with an input FIFO. It replaces the fixed-byte, single-shot transmit loop used for bring-up. Upstream logic pushes bytes with a simple write strobe. The block serialises them back-to-back at a configurable baud rate, word width, parity mode and stop-bit count. It sits between pulse-sequencer/debug logic and the RS232_Tx pin.

Parameters:
CLK_DIV, 1250, clock cycles per bit (12 MHz / 9600 baud); legal range >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
ADDR_W, $clog2(FIFO_DEPTH), derived, do not override

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active low
wr_en  input  1  push request
wr_data  input  DATA_BITS  word to push
full  output  1  FIFO holds FIFO_DEPTH words
empty  output  1  FIFO holds 0 words
level  output  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
overflow  output  1  sticky: a push was attempted while full
busy  output  1  frame in progress (is_transmitting equivalent)
tx  output  1  serial line, idle high

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset state, registered, seen the cycle after rst_n is sampled low: tx=1, busy=0, full=0, empty=1, level=0, overflow=0, state=IDLE, FIFO pointers=0.
- Reset mid-frame aborts the frame and discards FIFO contents. tx is 1 from the next cycle.
- FIFO accept rule: a push is accepted when wr_en=1 and full=0, both sampled in the same cycle.
  - A push while full is dropped and sets overflow. overflow clears only on reset.
  - A push and a pop in the same cycle while full: the push is still rejected. The full decision uses the pre-edge level.
  - A push and a pop in the same cycle while not full: level is unchanged.
- full, empty and level are registered and consistent with each other every cycle.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
  - IDLE: if empty=0, pop the head word into the shift register, set busy=1 and go to START. Otherwise tx=1 and busy=0.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: DATA_BITS bits, LSB first, CLK_DIV cycles each.
  - PARITY: present only when PARITY != 0; lasts CLK_DIV cycles.
    - Odd: the parity bit makes the total count of ones in data + parity odd.
    - Even: the parity bit makes that total even.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles.
  - On the final STOP cycle: if the FIFO is non-empty, pop and go directly to START, with no idle cycle between frames and busy held at 1. Otherwise go to IDLE, with busy=0 from the next cycle.
- Latency: a word pushed into an empty FIFO with the block in IDLE at edge N produces empty=0 after edge N. It is popped at edge N+1, and tx=0 / busy=1 are driven from edge N+1.
- Frame length: exactly CLK_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- Bit timer: counts 0..CLK_DIV-1 and wraps. The bit index counts 0..DATA_BITS-1.
- tx is driven from a flop, so the output is glitch-free.
- wr_data is captured at push time. Later changes on wr_data do not affect queued words.

Test Plan:
- CLK_DIV=4, 8N1: push 0x41 once -> tx holds 0 (start), then data bits 1,0,0,0,0,0,1,0, then 1 (stop), each for 4 cycles. busy=1 for exactly 40 cycles, starting the cycle after empty drops.
- PARITY=2 (even): push 0x41 -> parity bit 0. PARITY=1 (odd): push 0x41 -> parity bit 1. Frame length is 44 cycles.
- STOP_BITS=2: push 0x55 and 0xAA on consecutive cycles -> two frames of 44 cycles, no idle gap between them, busy never drops between frames. Second frame data bits are 0,1,0,1,0,1,0,1.
- FIFO_DEPTH=4: push 6 words while idle-blocked by a frame in progress -> level reaches 4, full=1, the 5th push sets overflow=1. The sent sequence equals the accepted words in order.
- Reset asserted mid-DATA with 3 words queued -> the next cycle shows tx=1, busy=0, empty=1, level=0, overflow=0, and nothing is transmitted after rst_n is released.
- DATA_BITS=7, CLK_DIV=2: push 0x7F -> seven 1-bits follow the start bit. Frame length is 18 cycles.
